// File: rtl/vload_pkg.sv
// Shared constants and types for the vector load packer.
// Optional feature macro VLOAD_STRIDE_EN is consumed by vload_packer and vload_addr_gen.
package vload_pkg;

    localparam int ELEM_W    = 16;
    localparam int NUM_ELEMS = 16;
    localparam int VLEN_W    = 4;
    localparam int MEM_AW    = 16;
    localparam int VEC_W     = ELEM_W * NUM_ELEMS;
    // Counters must hold 0..NUM_ELEMS inclusive.
    localparam int CNT_W     = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/vload_addr_gen.sv
// Memory request generator: owns the issue counter, the running element
// address and the mem_req handshake. When VLOAD_STRIDE_EN is undefined the
// top level feeds a constant stride of 1.
module vload_addr_gen
    import vload_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              active,
    input  logic [MEM_AW-1:0] base,
    input  logic [MEM_AW-1:0] stride,
    input  logic [CNT_W-1:0]  elem_cnt,
    input  logic              mem_req_ready,
    output logic              mem_req_valid,
    output logic [MEM_AW-1:0] mem_req_addr,
    output logic [CNT_W-1:0]  issue_cnt
);

    logic [MEM_AW-1:0] cur_addr;
    logic [MEM_AW-1:0] cur_stride;
    logic              fire;

    // A request is offered until every element of the vector has been issued.
    always_comb begin
        mem_req_valid = active && (issue_cnt < elem_cnt);
        mem_req_addr  = cur_addr;
        fire          = mem_req_valid && mem_req_ready;
    end

    // Running address replaces base + issue_cnt*stride; it only moves on an
    // accepted request, so the address is held stable while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_cnt  <= '0;
            cur_addr   <= '0;
            cur_stride <= '0;
        end else if (start) begin
            issue_cnt  <= '0;
            cur_addr   <= base;
            cur_stride <= stride;
        end else if (fire) begin
            issue_cnt  <= issue_cnt + CNT_W'(1);
            cur_addr   <= cur_addr + cur_stride;
        end
    end

endmodule

// File: rtl/vload_packer.sv
// Vector load packer: fetches req_len+1 16-bit elements from data memory,
// packs the in-order responses into a 256-bit vector and issues a single
// write to the vector register file.
// Optional feature: define VLOAD_STRIDE_EN to add the req_stride input.
module vload_packer
    import vload_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [VLEN_W-1:0] req_vreg,
    input  logic [MEM_AW-1:0] req_base,
    input  logic [VLEN_W-1:0] req_len,
`ifdef VLOAD_STRIDE_EN
    input  logic [MEM_AW-1:0] req_stride,
`endif
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [MEM_AW-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [ELEM_W-1:0] mem_rsp_data,
    output logic              wEn,
    output logic [VLEN_W-1:0] wAddr,
    output logic [VLEN_W-1:0] wLen,
    output logic [VEC_W-1:0]  wData,
    output logic              busy,
    output logic              rsp_err
);

    state_t            state;
    state_t            state_next;
    logic              accept;
    logic              rsp_take;
    logic              last_rsp;
    logic [VLEN_W-1:0] cur_vreg;
    logic [VLEN_W-1:0] cur_len;
    logic [CNT_W-1:0]  elem_cnt;
    logic [CNT_W-1:0]  rsp_cnt;
    logic [CNT_W-1:0]  issue_cnt;
    logic [VEC_W-1:0]  pack_buf;
    logic [VEC_W-1:0]  pack_next;
    logic [MEM_AW-1:0] stride;

`ifdef VLOAD_STRIDE_EN
    assign stride = req_stride;
`else
    assign stride = MEM_AW'(1);
`endif

    vload_addr_gen u_addr_gen (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (accept),
        .active        (state == FETCH),
        .base          (req_base),
        .stride        (stride),
        .elem_cnt      (elem_cnt),
        .mem_req_ready (mem_req_ready),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .issue_cnt     (issue_cnt)
    );

    // Response acceptance: issue_cnt is the registered count, so a request
    // handshaking this same cycle is not yet considered outstanding.
    always_comb begin
        accept    = (state == IDLE) && req_valid;
        rsp_take  = (state == FETCH) && mem_rsp_valid && (rsp_cnt < issue_cnt);
        last_rsp  = rsp_take && ((rsp_cnt + CNT_W'(1)) == elem_cnt);
        pack_next = pack_buf;
        if (rsp_take) begin
            pack_next[rsp_cnt[VLEN_W-1:0]*ELEM_W +: ELEM_W] = mem_rsp_data;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        busy       = 1'b0;
        wEn        = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy = 1'b1;
                if (last_rsp) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                busy       = 1'b1;
                wEn        = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Request latch, response counting and packing; a reset abandons the load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_vreg <= '0;
            cur_len  <= '0;
            elem_cnt <= '0;
            rsp_cnt  <= '0;
            pack_buf <= '0;
        end else if (accept) begin
            cur_vreg <= req_vreg;
            cur_len  <= req_len;
            elem_cnt <= {1'b0, req_len} + CNT_W'(1);
            rsp_cnt  <= '0;
            pack_buf <= '0;
        end else if (rsp_take) begin
            rsp_cnt  <= rsp_cnt + CNT_W'(1);
            pack_buf <= pack_next;
        end
    end

    // Write-port payload is captured with the last element and held until
    // the next completed load, so it never shows a partial vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wAddr <= '0;
            wLen  <= '0;
            wData <= '0;
        end else if (last_rsp) begin
            wAddr <= cur_vreg;
            wLen  <= cur_len;
            wData <= pack_next;
        end
    end

    // Sticky error for any response that has no outstanding request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (mem_rsp_valid && !rsp_take) begin
            rsp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_vload_packer.sv
// Self-checking bench for vload_packer with a scoreboard of expected
// register-file writes and expected memory addresses.
module tb_vload_packer;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [3:0]   req_vreg = '0;
    logic [15:0]  req_base = '0;
    logic [3:0]   req_len = '0;
`ifdef VLOAD_STRIDE_EN
    logic [15:0]  req_stride = 16'd1;
`endif
    logic         mem_req_valid;
    logic         mem_req_ready = 1'b1;
    logic [15:0]  mem_req_addr;
    logic         mem_rsp_valid = 1'b0;
    logic [15:0]  mem_rsp_data = '0;
    logic         wEn;
    logic [3:0]   wAddr;
    logic [3:0]   wLen;
    logic [255:0] wData;
    logic         busy;
    logic         rsp_err;

    always #5 clk = ~clk;

    vload_packer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_vreg      (req_vreg),
        .req_base      (req_base),
        .req_len       (req_len),
`ifdef VLOAD_STRIDE_EN
        .req_stride    (req_stride),
`endif
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .wEn           (wEn),
        .wAddr         (wAddr),
        .wLen          (wLen),
        .wData         (wData),
        .busy          (busy),
        .rsp_err       (rsp_err)
    );

    typedef struct {
        logic [3:0]   vreg;
        logic [3:0]   len;
        logic [255:0] data;
        int           lat;
        int           acc;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] exp_addr_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: always-ready or patterned ready, 1-cycle response latency.
    bit          pend = 1'b0;
    logic [15:0] pend_addr = '0;
    int          ready_mode = 0;
    int          rdy_idx = 0;
    int          hs_cnt = 0;
    int          rsp_total = 0;
    bit          inject = 1'b0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_addr = '0;
    bit          pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    always @(negedge clk) begin : mem_model
        logic [15:0] ea;
        if (!rst_n) begin
            pend          = 1'b0;
            mem_rsp_valid = 1'b0;
            mem_req_ready = 1'b1;
            prev_stall    = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", 256'(mem_req_valid), 256'(1'b1));
                chk("stall_addr", 256'(mem_req_addr), 256'(prev_addr));
            end
            if (pend) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = pend_addr ^ 16'hA5A5;
                rsp_total++;
            end else if (inject) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = 16'hDEAD;
                inject        = 1'b0;
            end else begin
                mem_rsp_valid = 1'b0;
            end
            pend = 1'b0;
            mem_req_ready = (ready_mode == 0) ? 1'b1 : pat[rdy_idx % 4];
            rdy_idx++;
            if (mem_req_valid && mem_req_ready) begin
                pend      = 1'b1;
                pend_addr = mem_req_addr;
                hs_cnt++;
                ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 16'hxxxx;
                chk("mem_addr", 256'(mem_req_addr), 256'(ea));
            end
            prev_stall = mem_req_valid && !mem_req_ready;
            prev_addr  = mem_req_addr;
        end
    end

    // Write-port monitor: pops the scoreboard on each wEn pulse.
    int wen_total    = 0;
    int last_wen_cyc = -10;
    bit prev_wen     = 1'b0;

    always @(negedge clk) begin : wr_mon
        exp_t e;
        if (rst_n && wEn) begin
            wen_total++;
            last_wen_cyc = cyc;
            chk("wen_pulse_width", 256'(prev_wen), 256'(1'b0));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
            end else begin
                e.vreg = 'x; e.len = 'x; e.data = 'x; e.lat = -1; e.acc = 0;
            end
            chk("wAddr", 256'(wAddr), 256'(e.vreg));
            chk("wLen", 256'(wLen), 256'(e.len));
            chk("wData", wData, e.data);
            if (e.lat >= 0) chk("latency", 256'(cyc - e.acc), 256'(e.lat));
        end
        prev_wen = rst_n && wEn;
    end

    // Queue the expectation, present the request and hold it until accepted.
    // Called and returns on a falling edge.
    task automatic do_load(input logic [3:0] vreg, input logic [15:0] base,
                           input logic [3:0] len, input logic [15:0] stride,
                           input int lat, output int acc);
        exp_t        e;
        logic [15:0] a;
        int          n;
        n = int'(len) + 1;
        e.vreg = vreg; e.len = len; e.data = '0; e.lat = lat; e.acc = 0;
        for (int i = 0; i < n; i++) begin
            a = 16'(base + 16'(i) * stride);
            e.data[i*16 +: 16] = a ^ 16'hA5A5;
            exp_addr_q.push_back(a);
        end
        exp_q.push_back(e);
        req_vreg  = vreg;
        req_base  = base;
        req_len   = len;
`ifdef VLOAD_STRIDE_EN
        req_stride = stride;
`endif
        req_valid = 1'b1;
        acc = -1;
        for (int k = 0; k < 200; k++) begin
            if (req_ready) break;
            @(negedge clk);
        end
        chk("req_accept", 256'(req_ready), 256'(1'b1));
        acc = cyc;
        exp_q[exp_q.size()-1].acc = acc;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 300; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("load_done", 256'(exp_q.size()), 256'(0));
        @(negedge clk);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int acc1, acc2, w0, h0, r0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", 256'(req_ready), 256'(1'b1));
        chk("rst_busy", 256'(busy), 256'(1'b0));
        chk("rst_wen", 256'(wEn), 256'(1'b0));
        chk("rst_mem_req_valid", 256'(mem_req_valid), 256'(1'b0));
        chk("rst_rsp_err", 256'(rsp_err), 256'(1'b0));
        chk("rst_wdata", wData, 256'(0));

        // Reset in the middle of a fetch abandons the load.
        w0 = wen_total;
        r0 = rsp_total;
        do_load(4'd3, 16'h0100, 4'd15, 16'd1, -1, acc1);
        for (int k = 0; k < 100; k++) begin
            if (rsp_total - r0 >= 5) break;
            @(negedge clk);
        end
        chk("midreset_rsp_seen", 256'(rsp_total - r0 >= 5), 256'(1'b1));
        chk("midreset_busy_before", 256'(busy), 256'(1'b1));
        rst_n = 1'b0;
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_no_wen", 256'(wen_total), 256'(w0));
        chk("midreset_req_ready", 256'(req_ready), 256'(1'b1));
        chk("midreset_busy", 256'(busy), 256'(1'b0));

        // Full vector with ideal memory: accept-to-write latency of 18.
        w0 = wen_total;
        do_load(4'd3, 16'h0100, 4'd15, 16'd1, 18, acc1);
        wait_done();
        chk("full_one_wen", 256'(wen_total - w0), 256'(1));

        // Short vector: exactly three requests, upper slots zero.
        h0 = hs_cnt;
        do_load(4'd7, 16'h0020, 4'd2, 16'd1, -1, acc1);
        wait_done();
        chk("short_req_count", 256'(hs_cnt - h0), 256'(3));

        // Stalled memory and address wrap-around.
        ready_mode = 1;
        rdy_idx    = 0;
        do_load(4'd1, 16'hFFFE, 4'd3, 16'd1, -1, acc1);
        wait_done();
        ready_mode = 0;

        // Back-to-back: second request held through FETCH and WRITE.
        do_load(4'd2, 16'h0300, 4'd4, 16'd1, -1, acc1);
        do_load(4'd5, 16'h0400, 4'd1, 16'd1, -1, acc2);
        chk("b2b_accept_after_wen", 256'(acc2), 256'(last_wen_cyc + 1));
        wait_done();

        // Stray response in IDLE sets the sticky error.
        chk("err_before_stray", 256'(rsp_err), 256'(1'b0));
        inject = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_after_stray", 256'(rsp_err), 256'(1'b1));
        do_load(4'd6, 16'h0050, 4'd0, 16'd1, -1, acc1);
        wait_done();
        chk("err_sticky", 256'(rsp_err), 256'(1'b1));

`ifdef VLOAD_STRIDE_EN
        h0 = hs_cnt;
        do_load(4'd4, 16'h0010, 4'd3, 16'd4, -1, acc1);
        wait_done();
        do_load(4'd4, 16'h0010, 4'd3, 16'd0, -1, acc1);
        wait_done();
        chk("stride_req_count", 256'(hs_cnt - h0), 256'(8));
`endif

        chk("addr_queue_drained", 256'(exp_addr_q.size()), 256'(0));
        chk("final_idle", 256'(busy), 256'(1'b0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vload_packer.md
Name: vload_packer

Overview:
- Writer-side companion to the vector register file.
- Accepts a "load vector" request (destination vreg, base address, length) and fetches 16-bit elements from data memory, one request per element.
- Packs the in-order responses into a 256-bit vector.
- Issues exactly one write-port transaction (wEn/wAddr/wLen/wData) to the vector register file.

Parameters:
- ELEM_W, 16, element width in bits
- NUM_ELEMS, 16, elements per vector register
- MEM_AW, 16, memory element-address width

Ports:
- clk  input  1  clock, all state on posedge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  load request present
- req_ready  output  1  block can accept request (IDLE only)
- req_vreg  input  4  destination vector register
- req_base  input  MEM_AW  element address of element 0
- req_len  input  4  vector length field; element count = req_len+1 (1..16)
- mem_req_valid  output  1  memory read request
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  MEM_AW  element address
- mem_rsp_valid  input  1  read data valid; in order, never back-pressured
- mem_rsp_data  input  ELEM_W  read data
- wEn  output  1  register-file write strobe, single-cycle pulse
- wAddr  output  4  register-file write index
- wLen  output  4  register-file length field (= latched req_len)
- wData  output  256  packed vector; element i at bits [16i+15:16i]
- busy  output  1  high in FETCH or WRITE
- rsp_err  output  1  sticky; set by a response arriving while none outstanding

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE; all counters = 0; pack buffer = 0.
  - wEn = 0, mem_req_valid = 0, busy = 0, rsp_err = 0, req_ready = 1 after release.
  - A load in progress is abandoned; no partial write occurs.
- States: IDLE, FETCH, WRITE.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch vreg, base, len; set n = len+1; clear issue_cnt, rsp_cnt and buffer; go to FETCH.
- FETCH, issue side:
  - mem_req_valid = 1 while issue_cnt < n; mem_req_addr = base + issue_cnt, modulo 2^MEM_AW (wrap-around allowed).
  - issue_cnt increments on mem_req_valid && mem_req_ready.
  - mem_req_addr and mem_req_valid are held stable while stalled.
- FETCH, response side:
  - On mem_rsp_valid with rsp_cnt < issue_cnt (counting a same-cycle handshake as not yet issued): write data into slot rsp_cnt; increment rsp_cnt.
  - A response with nothing outstanding is dropped and sets rsp_err.
- FETCH exit: when rsp_cnt reaches n (last response accepted), go to WRITE next cycle.
- WRITE:
  - wEn = 1 for exactly one cycle; wAddr = vreg, wLen = len, wData = buffer.
  - Slots >= n are zero.
  - Next state IDLE; req_ready is low during WRITE.
- wData/wAddr/wLen are valid only while wEn = 1; otherwise they hold last values.
- Timing:
  - Memory response arrives >= 1 cycle after request acceptance.
  - Minimum latency from request accept to wEn = n+2 cycles with an always-ready, 1-cycle memory.
- Back-to-back: a request presented during WRITE is accepted on the following IDLE cycle.
- Responses outside FETCH set rsp_err and are dropped.
- Widths: counters are 5 bits (0..16); address add truncates to MEM_AW.

Optional Feature:
- Macro VLOAD_STRIDE_EN.
- Defined: adds input req_stride [MEM_AW-1:0], latched with the request; mem_req_addr = base + issue_cnt*req_stride (truncated to MEM_AW). Stride 0 = broadcast of one address.
- Undefined: port absent, stride fixed at 1.

Decomposition:
- Package vload_pkg:
  - ELEM_W, NUM_ELEMS, VLEN_W = 4
  - state enum {IDLE, FETCH, WRITE}
  - helper constant VEC_W = ELEM_W*NUM_ELEMS = 256
- One sub-module: vload_addr_gen. Owns the issue counter, stride/base addition and the mem_req handshake; reports issue_cnt to the top-level FSM and packer.

Test Plan:
- Reset mid-FETCH:
  - Stimulus: vreg 3, base 0x0100, len 15; rst_n low after 5 responses.
  - Required: wEn never asserts; after release req_ready = 1, busy = 0.
- Full vector:
  - Stimulus: vreg 3, base 0x0100, len 15; memory returns addr^0xA5A5, always ready, 1-cycle latency.
  - Required: one wEn pulse 18 cycles after accept; wAddr = 3; wLen = 15; element i = (0x0100+i)^0xA5A5.
- Short vector:
  - Stimulus: vreg 7, base 0x0020, len 2.
  - Required: exactly 3 mem requests (0x20, 0x21, 0x22); wData[47:0] = returned data; wData[255:48] = 0; wLen = 2.
- Stalls and wrap:
  - Stimulus: base 0xFFFE, len 3; mem_req_ready toggling 1,0,0,1.
  - Required: addresses 0xFFFE, 0xFFFF, 0x0000, 0x0001, each held stable while stalled; packed order preserved.
- Back-to-back and error:
  - Stimulus: second request held during WRITE; a stray mem_rsp_valid in IDLE.
  - Required: second request accepted the cycle after wEn; rsp_err = 1 and stays set; vector contents unaffected.
- Stride (VLOAD_STRIDE_EN):
  - Stimulus: base 0x0010, stride 4, len 3.
  - Required: addresses 0x10, 0x14, 0x18, 0x1C.
  - Stimulus: stride 0.
  - Required: four requests to 0x10.
